// File: rtl/operand_fwd_sel_if.sv
// Decode-to-EX forwarding bus: the ID-stage instruction fields going in, the
// EX operand-mux selects and the load-use stall coming back.
interface operand_fwd_sel_if #(
  parameter int RA_W = 5
);
  logic            id_valid;
  logic [RA_W-1:0] id_rs1;
  logic [RA_W-1:0] id_rs2;
  logic            id_rs1_used;
  logic            id_rs2_used;
  logic            id_a_pc;
  logic            id_b_imm;
  logic [RA_W-1:0] id_rd;
  logic            id_we;
  logic            id_is_load;
  logic            flush;
  logic [2:0]      sel_a;
  logic [2:0]      sel_b;
  logic            stall;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_a_pc,
           id_b_imm, id_rd, id_we, id_is_load, flush,
    input  sel_a, sel_b, stall
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_a_pc,
           id_b_imm, id_rd, id_we, id_is_load, flush,
    output sel_a, sel_b, stall
  );
endinterface

// File: rtl/operand_fwd_sel.sv
// EX-stage operand forwarding select and load-use stall, with a private EX/MEM/WB
// tag pipeline. Define FWD_WB2_EN to add the WB2 slot (select 011).
module operand_fwd_sel #(
  parameter int RA_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  operand_fwd_sel_if.slave  fs
);

`ifdef FWD_WB2_EN
  localparam int NSLOT = 4;
`else
  localparam int NSLOT = 3;
`endif

  localparam logic [2:0] SEL_RF   = 3'b000;
  localparam logic [2:0] SEL_IMM  = 3'b100;
  localparam logic [2:0] SEL_PC   = 3'b101;
  localparam logic [2:0] SEL_ZERO = 3'b110;

  typedef struct packed {
    logic            valid;
    logic [RA_W-1:0] rs1;
    logic [RA_W-1:0] rs2;
    logic            rs1_used;
    logic            rs2_used;
    logic            a_pc;
    logic            b_imm;
  } cons_t;

  typedef struct packed {
    logic            valid;
    logic            we;
    logic [RA_W-1:0] rd;
  } prod_t;

  cons_t                 cons_q, cons_d;
  prod_t [NSLOT-1:0]     slot_q, slot_d;
  logic                  ex_load_q, ex_load_d;
  logic                  stall;
  logic                  issue;
  logic [NSLOT-1:1]      hit_a, hit_b;
  logic [2:0]            sel_a, sel_b;

  // Slot 0 is EX; only the EX occupant can cause a load-use hazard.
  always_comb begin
    stall = fs.id_valid & slot_q[0].valid & slot_q[0].we & ex_load_q &
            (slot_q[0].rd != '0) &
            ((fs.id_rs1_used & (fs.id_rs1 == slot_q[0].rd)) |
             (fs.id_rs2_used & (fs.id_rs2 == slot_q[0].rd)));
  end

  always_comb begin
    issue     = fs.id_valid & ~stall & ~fs.flush;
    cons_d    = '0;
    ex_load_d = 1'b0;
    slot_d[0] = '0;
    if (issue) begin
      cons_d.valid    = 1'b1;
      cons_d.rs1      = fs.id_rs1;
      cons_d.rs2      = fs.id_rs2;
      cons_d.rs1_used = fs.id_rs1_used;
      cons_d.rs2_used = fs.id_rs2_used;
      cons_d.a_pc     = fs.id_a_pc;
      cons_d.b_imm    = fs.id_b_imm;
      slot_d[0].valid = 1'b1;
      slot_d[0].we    = fs.id_we;
      slot_d[0].rd    = fs.id_rd;
      ex_load_d       = fs.id_is_load;
    end
    for (int k = 1; k < NSLOT; k++) begin
      slot_d[k] = slot_q[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cons_q    <= '0;
      slot_q    <= '0;
      ex_load_q <= 1'b0;
    end else begin
      cons_q    <= cons_d;
      slot_q    <= slot_d;
      ex_load_q <= ex_load_d;
    end
  end

  genvar gi;
  generate
    for (gi = 1; gi < NSLOT; gi++) begin : g_hit
      assign hit_a[gi] = slot_q[gi].valid & slot_q[gi].we & (slot_q[gi].rd != '0) &
                         (slot_q[gi].rd == cons_q.rs1);
      assign hit_b[gi] = slot_q[gi].valid & slot_q[gi].we & (slot_q[gi].rd != '0) &
                         (slot_q[gi].rd == cons_q.rs2);
    end
  endgenerate

  // Slot index k doubles as its select code (MEM=1, WB=2, WB2=3); scanning
  // oldest-first lets the youngest matching producer win.
  always_comb begin
    sel_a = SEL_RF;
    if (cons_q.valid) begin
      if (cons_q.a_pc) begin
        sel_a = SEL_PC;
      end else if (!cons_q.rs1_used || (cons_q.rs1 == '0)) begin
        sel_a = SEL_ZERO;
      end else begin
        for (int k = NSLOT - 1; k >= 1; k--) begin
          if (hit_a[k]) sel_a = 3'(k);
        end
      end
    end
  end

  always_comb begin
    sel_b = SEL_RF;
    if (cons_q.valid) begin
      if (cons_q.b_imm) begin
        sel_b = SEL_IMM;
      end else if (!cons_q.rs2_used || (cons_q.rs2 == '0)) begin
        sel_b = SEL_ZERO;
      end else begin
        for (int k = NSLOT - 1; k >= 1; k--) begin
          if (hit_b[k]) sel_b = 3'(k);
        end
      end
    end
  end

  assign fs.sel_a = sel_a;
  assign fs.sel_b = sel_b;
  assign fs.stall = stall;

endmodule

// File: tb/tb_operand_fwd_sel.sv
// Bench for operand_fwd_sel: directed forwarding scenarios with literal
// expectations, then random traffic checked each cycle against a history model.
module tb_operand_fwd_sel;
  localparam int RA_W = 5;
`ifdef FWD_WB2_EN
  localparam int         NPROD    = 3;
  localparam logic [2:0] GAP2_SEL = 3'b011;
`else
  localparam int         NPROD    = 2;
  localparam logic [2:0] GAP2_SEL = 3'b000;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;

  operand_fwd_sel_if #(.RA_W(RA_W)) bus ();
  operand_fwd_sel #(.RA_W(RA_W)) dut (.clk(clk), .rst(rst), .fs(bus));

  always #5 clk = ~clk;

  // hist[0] is what sits in EX, hist[n] is what entered EX n cycles earlier.
  typedef struct {
    bit v;
    int rs1, rs2;
    bit u1, u2, apc, bimm;
    int rd;
    bit we, ld;
  } rec_t;

  rec_t hist[4];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic bit m_stall();
    rec_t x = hist[0];
    return bus.id_valid && x.v && x.we && x.ld && (x.rd != 0) &&
           ((bus.id_rs1_used && (int'(bus.id_rs1) == x.rd)) ||
            (bus.id_rs2_used && (int'(bus.id_rs2) == x.rd)));
  endfunction

  function automatic rec_t m_enter();
    rec_t e = '{default: 0};
    if (bus.id_valid && !m_stall() && !bus.flush) begin
      e.v    = 1'b1;
      e.rs1  = int'(bus.id_rs1);
      e.rs2  = int'(bus.id_rs2);
      e.u1   = bus.id_rs1_used;
      e.u2   = bus.id_rs2_used;
      e.apc  = bus.id_a_pc;
      e.bimm = bus.id_b_imm;
      e.rd   = int'(bus.id_rd);
      e.we   = bus.id_we;
      e.ld   = bus.id_is_load;
    end
    return e;
  endfunction

  function automatic logic [2:0] m_sel(bit is_a);
    rec_t c = hist[0];
    int   rs;
    bit   u;
    if (!c.v) return 3'b000;
    if (is_a && c.apc) return 3'b101;
    if (!is_a && c.bimm) return 3'b100;
    rs = is_a ? c.rs1 : c.rs2;
    u  = is_a ? c.u1 : c.u2;
    if (!u || rs == 0) return 3'b110;
    for (int age = 1; age <= NPROD; age++) begin
      if (hist[age].v && hist[age].we && hist[age].rd == rs) return 3'(age);
    end
    return 3'b000;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) hist[i] <= '{default: 0};
    end else begin
      hist[0] <= m_enter();
      hist[1] <= hist[0];
      hist[2] <= hist[1];
      hist[3] <= hist[2];
    end
  end

  task automatic chk(input string nm, input logic [2:0] act, input logic [2:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("cyc_sel_a", bus.sel_a, m_sel(1'b1));
    chk("cyc_sel_b", bus.sel_b, m_sel(1'b0));
    chk("cyc_stall", {2'b00, bus.stall}, {2'b00, m_stall()});
  end

  task automatic set_id(input bit v, input int rs1, input int rs2, input bit u1, input bit u2,
                        input bit apc, input bit bimm, input int rd, input bit we,
                        input bit ld, input bit fl);
    bus.id_valid    = v;
    bus.id_rs1      = RA_W'(rs1);
    bus.id_rs2      = RA_W'(rs2);
    bus.id_rs1_used = u1;
    bus.id_rs2_used = u2;
    bus.id_a_pc     = apc;
    bus.id_b_imm    = bimm;
    bus.id_rd       = RA_W'(rd);
    bus.id_we       = we;
    bus.id_is_load  = ld;
    bus.flush       = fl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic nop();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
  endtask

  task automatic drain();
    for (int i = 0; i < 5; i++) nop();
  endtask

  task automatic show(input string nm);
    $display("dir %-10s sel_a=%b sel_b=%b stall=%b", nm, bus.sel_a, bus.sel_b, bus.stall);
  endtask

  bit hold;

  initial begin
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sel_a", bus.sel_a, 3'b000);
    chk("rst_stall", {2'b00, bus.stall}, 3'b000);
    rst = 1'b1;
    drain();

    // back-to-back, one gap, two gaps
    set_id(1, 1, 2, 1, 1, 0, 0, 5, 1, 0, 0); step();
    set_id(1, 5, 5, 1, 1, 0, 0, 6, 1, 0, 0); step();
    show("b2b");
    chk("b2b_a", bus.sel_a, 3'b001);
    chk("b2b_b", bus.sel_b, 3'b001);
    drain();
    set_id(1, 1, 2, 1, 1, 0, 0, 5, 1, 0, 0); step();
    nop();
    set_id(1, 5, 5, 1, 1, 0, 0, 6, 1, 0, 0); step();
    show("gap1");
    chk("gap1_a", bus.sel_a, 3'b010);
    chk("gap1_b", bus.sel_b, 3'b010);
    drain();
    set_id(1, 1, 2, 1, 1, 0, 0, 5, 1, 0, 0); step();
    nop();
    nop();
    set_id(1, 5, 5, 1, 1, 0, 0, 6, 1, 0, 0); step();
    show("gap2");
    chk("gap2_a", bus.sel_a, GAP2_SEL);
    chk("gap2_b", bus.sel_b, GAP2_SEL);
    drain();

    // load-use: one stall cycle, one bubble, then WB forward
    set_id(1, 2, 0, 1, 0, 0, 0, 7, 1, 1, 0); step();
    set_id(1, 7, 1, 1, 1, 0, 0, 8, 1, 0, 0); #1;
    chk("lu_stall1", {2'b00, bus.stall}, 3'b001);
    step();
    chk("lu_stall0", {2'b00, bus.stall}, 3'b000);
    chk("lu_bub_a", bus.sel_a, 3'b000);
    chk("lu_bub_b", bus.sel_b, 3'b000);
    step();
    show("load_use");
    chk("lu_a", bus.sel_a, 3'b010);
    chk("lu_b", bus.sel_b, 3'b000);
    drain();

    // x0 reader, immediate and PC overrides
    set_id(1, 1, 2, 1, 1, 0, 0, 0, 1, 0, 0); step();
    set_id(1, 0, 0, 1, 1, 0, 0, 3, 1, 0, 0); step();
    show("x0");
    chk("x0_a", bus.sel_a, 3'b110);
    chk("x0_b", bus.sel_b, 3'b110);
    drain();
    set_id(1, 1, 2, 1, 1, 0, 0, 9, 1, 0, 0); step();
    set_id(1, 9, 9, 1, 1, 0, 1, 3, 1, 0, 0); step();
    show("imm");
    chk("imm_a", bus.sel_a, 3'b001);
    chk("imm_b", bus.sel_b, 3'b100);
    drain();
    set_id(1, 1, 2, 1, 1, 0, 0, 9, 1, 0, 0); step();
    set_id(1, 9, 9, 1, 1, 1, 0, 3, 1, 0, 0); step();
    show("pc");
    chk("pc_a", bus.sel_a, 3'b101);
    chk("pc_b", bus.sel_b, 3'b001);
    drain();

    // flush coinciding with a load-use stall
    set_id(1, 2, 0, 1, 0, 0, 0, 7, 1, 1, 0); step();
    set_id(1, 7, 1, 1, 1, 0, 0, 8, 1, 0, 1); #1;
    chk("fl_stall1", {2'b00, bus.stall}, 3'b001);
    step();
    show("flush");
    chk("fl_bub_a", bus.sel_a, 3'b000);
    chk("fl_bub_b", bus.sel_b, 3'b000);
    set_id(1, 7, 1, 1, 1, 0, 0, 8, 1, 0, 0); #1;
    chk("fl_stall0", {2'b00, bus.stall}, 3'b000);
    step();
    chk("fl_after_a", bus.sel_a, 3'b010);
    drain();

    // youngest producer wins
    set_id(1, 1, 2, 1, 1, 0, 0, 5, 1, 0, 0); step();
    set_id(1, 2, 3, 1, 1, 0, 0, 5, 1, 0, 0); step();
    set_id(1, 5, 5, 1, 1, 0, 0, 6, 1, 0, 0); step();
    show("priority");
    chk("prio_a", bus.sel_a, 3'b001);
    chk("prio_b", bus.sel_b, 3'b001);
    drain();

    // reset mid-stream with a live forward and a pending stall
    set_id(1, 1, 2, 1, 1, 0, 0, 5, 1, 0, 0); step();
    set_id(1, 5, 0, 1, 0, 0, 0, 7, 1, 1, 0); step();
    chk("mr_pre_a", bus.sel_a, 3'b001);
    set_id(1, 7, 1, 1, 1, 0, 0, 8, 1, 0, 0); #1;
    chk("mr_pre_stall", {2'b00, bus.stall}, 3'b001);
    rst = 1'b0; #1;
    show("reset_mid");
    chk("mr_a", bus.sel_a, 3'b000);
    chk("mr_b", bus.sel_b, 3'b000);
    chk("mr_stall", {2'b00, bus.stall}, 3'b000);
    @(posedge clk); #3;
    rst = 1'b1;
    set_id(1, 5, 7, 1, 1, 0, 0, 8, 1, 0, 0); step();
    chk("mr_post_a", bus.sel_a, 3'b000);
    chk("mr_post_b", bus.sel_b, 3'b000);
    drain();

    // random traffic; ID holds its instruction while stalled
    hold = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (!hold) begin
        set_id($urandom_range(0, 9) < 8, $urandom_range(0, 7), $urandom_range(0, 7),
               $urandom_range(0, 4) != 0, $urandom_range(0, 4) != 0,
               $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
               $urandom_range(0, 7), $urandom_range(0, 9) < 7,
               $urandom_range(0, 9) < 3, 1'b0);
      end
      bus.flush = ($urandom_range(0, 9) == 0);
      #1;
      hold = bus.stall;
      step();
      if (i == 2000) begin
        rst = 1'b0;
        #2;
        rst = 1'b1;
      end
    end
    nop();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
